// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID: show-ahead FIFO of {inst, pc} pairs.
// Presents a NOP bubble when empty and drops all contents on flush.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_enq_valid,
    output logic                       o_enq_ready,
    input  logic [31:0]                i_enq_inst,
    input  logic [31:0]                i_enq_pc,
    output logic                       o_deq_valid,
    input  logic                       i_deq_ready,
    output logic [31:0]                o_deq_inst,
    output logic [31:0]                o_deq_pc,
    output logic [31:0]                o_deq_pc_plus_4,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          enq_fire_c;
    logic          deq_fire_c;
    entry_t        head_c;

    assign o_full      = (count == CW'(DEPTH));
    assign o_empty     = (count == '0);
    assign o_enq_ready = ~o_full;
    assign o_deq_valid = ~o_empty;
    assign o_count     = count;

    assign enq_fire_c = i_enq_valid & o_enq_ready;
    assign deq_fire_c = i_deq_ready & o_deq_valid;

    // Pointers and occupancy; flush clears everything and discards same-cycle fires
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire_c) wr_ptr <= wr_ptr + AW'(1);
            if (deq_fire_c) rd_ptr <= rd_ptr + AW'(1);
            case ({enq_fire_c, deq_fire_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array is intentionally not reset
    always_ff @(posedge i_clk) begin
        if (enq_fire_c && !i_flush && !i_rst) begin
            mem[wr_ptr] <= '{inst: i_enq_inst, pc: i_enq_pc};
        end
    end

    // Head is masked when empty so stale or uninitialised entries never reach ID
    assign head_c          = mem[rd_ptr];
    assign o_deq_inst      = o_empty ? NOP_INST : head_c.inst;
    assign o_deq_pc        = o_empty ? 32'h0    : head_c.pc;
    assign o_deq_pc_plus_4 = o_deq_pc + 32'd4;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised + directed scoreboard bench for fetch_queue against a queue-based model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_enq_valid = 1'b0;
    logic        o_enq_ready;
    logic [31:0] i_enq_inst = '0;
    logic [31:0] i_enq_pc = '0;
    logic        o_deq_valid;
    logic        i_deq_ready = 1'b0;
    logic [31:0] o_deq_inst;
    logic [31:0] o_deq_pc;
    logic [31:0] o_deq_pc_plus_4;
    logic [2:0]  o_count;
    logic        o_full;
    logic        o_empty;

    fetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_enq_valid(i_enq_valid), .o_enq_ready(o_enq_ready),
        .i_enq_inst(i_enq_inst), .i_enq_pc(i_enq_pc),
        .o_deq_valid(o_deq_valid), .i_deq_ready(i_deq_ready),
        .o_deq_inst(o_deq_inst), .o_deq_pc(o_deq_pc),
        .o_deq_pc_plus_4(o_deq_pc_plus_4), .o_count(o_count),
        .o_full(o_full), .o_empty(o_empty)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t sb[$];
    int   model_cnt = 0;
    int   checks = 0;
    int   failures = 0;
    bit   started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One cycle: check state-derived outputs, drive inputs, advance the model
    task automatic cyc(input bit ev, input logic [31:0] inst, input logic [31:0] pc,
                       input bit dr, input bit fl, input bit rs);
        bit enq, deq;
        @(negedge i_clk);
        chk("count",     32'(o_count),     32'(model_cnt));
        chk("empty",     32'(o_empty),     32'(model_cnt == 0));
        chk("full",      32'(o_full),      32'(model_cnt == DEPTH));
        chk("enq_ready", 32'(o_enq_ready), 32'(model_cnt != DEPTH));
        chk("deq_valid", 32'(o_deq_valid), 32'(model_cnt != 0));
        i_enq_valid = ev;
        i_enq_inst  = inst;
        i_enq_pc    = pc;
        i_deq_ready = dr;
        i_flush     = fl;
        i_rst       = rs;
        enq = ev && (model_cnt < DEPTH);
        deq = dr && (model_cnt > 0);
        if (rs || fl) begin
            sb.delete();
            model_cnt = 0;
        end else begin
            if (enq) sb.push_back('{inst: inst, pc: pc});
            model_cnt = model_cnt + int'(enq) - int'(deq);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands an entry to ID
    initial begin : monitor
        ent_t e;
        wait (started);
        forever begin
            @(negedge i_clk);
            #1;
            if (!i_rst && !i_flush) begin
                if (o_deq_valid === 1'b1 && i_deq_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL deq_unexpected actual_pc=%h required=no_entry t=%0t", o_deq_pc, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("deq_inst", o_deq_inst, e.inst);
                        chk("deq_pc", o_deq_pc, e.pc);
                        chk("deq_pc_plus_4", o_deq_pc_plus_4, e.pc + 32'd4);
                    end
                end else if (o_deq_valid !== 1'b1) begin
                    chk("nop_inst", o_deq_inst, NOP);
                    chk("nop_pc", o_deq_pc, 32'h0);
                    chk("nop_pc_plus_4", o_deq_pc_plus_4, 32'h4);
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] pc_ctr;
        bit ev, dr, fl, rs;
        repeat (2) @(posedge i_clk);
        started = 1'b1;
        i_rst = 1'b0;

        idle(3);

        // Fill to full, drop a 5th, then drain in order
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 32'hA0 + 32'(i), 32'(4 * i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hA4, 32'h10, 1'b0, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Steady stream across pointer wrap
        for (int i = 0; i < 11; i++)
            cyc(1'b1, 32'hB0 + 32'(i), 32'h200 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Flush with simultaneous enq (pc 40) and deq
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'hC0 + 32'(i), 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hC4, 32'h40, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Full with simultaneous enq and deq: enq refused, retried next cycle
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 32'hD0 + 32'(i), 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hD4, 32'h410, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hD4, 32'h410, 1'b0, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation, then a fresh entry reaches the head
        cyc(1'b1, 32'hE0, 32'h500, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hE1, 32'h504, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(1);
        cyc(1'b1, 32'hE2, 32'h100, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // pc+4 wraps modulo 2^32
        cyc(1'b1, 32'hF0, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Random traffic with occasional flush and reset
        pc_ctr = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            ev = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 31) == 0);
            rs = ($urandom_range(0, 63) == 0);
            cyc(ev, $urandom, pc_ctr, dr, fl, rs);
            if (ev) pc_ctr = pc_ctr + 32'd4;
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
